// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
//
// Measures the frequency of an external square wave. It counts the rising
// edges of sig_in over a gate window of GATE_CYCLES clk cycles and reports
// the count once per window. It is the receiving end of the clock-divider /
// tick-generator output, so it is used at bring-up to read divider ratios
// back.
//
// Parameters:
//   GATE_CYCLES  gate window length in clk cycles (>= 2)
//   CNT_W        width of the edge counter and of count_out
//   SYNC_STAGES  synchronizer flops on sig_in (>= 2)
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        asynchronous active-high reset
//   en         measurement enable, synchronous to clk
//   sig_in     signal under measurement, asynchronous to clk
//   count_out  rising-edge count of the last completed window (saturating)
//   valid      one-cycle pulse when count_out/overflow are updated
//   overflow   last completed window had more edges than count_out can hold
// ---------------------------------------------------------------------------
module freq_meter #(
   parameter int GATE_CYCLES = 12000000,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] count_out,
   output logic             valid,
   output logic             overflow
);

   localparam int GATE_W = $clog2(GATE_CYCLES);

   // Gate counter value on the last cycle of a window.
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   // Saturation value of the edge counter.
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE,
      MEASURE
   } state_t;

   state_t                 state;
   logic [GATE_W-1:0]      gate_cnt;
   logic [CNT_W-1:0]       edge_cnt;
   logic                   win_ovf;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sig_prev;
   logic                   sig_sync;
   logic                   rise;
   logic                   edge_at_max;
   logic                   gate_end;
   logic [CNT_W-1:0]       edge_next;
   logic                   ovf_next;

   // sig_in is asynchronous, so it is brought into the clk domain through a
   // flop chain before anything looks at it. sig_prev holds the synchronized
   // value one cycle back for edge detection. Both run in every state, so a
   // signal that is already high when en asserts never looks like a fresh
   // edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         sig_prev <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
         sig_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sig_sync = sync_q[SYNC_STAGES-1];
   assign rise     = sig_sync & ~sig_prev;

   // Saturating edge count including any rise seen this cycle. A rise that
   // arrives while the counter is already at its maximum is recorded in the
   // window overflow flag instead of wrapping the count.
   assign edge_at_max = (edge_cnt == CNT_MAX);
   assign edge_next   = (rise && !edge_at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
   assign ovf_next    = win_ovf | (rise & edge_at_max);
   assign gate_end    = (gate_cnt == GATE_LAST);

   // Measurement FSM. IDLE holds the window counters cleared until en is
   // seen. MEASURE runs windows back to back: on the last gate cycle the
   // result (including a rise in that very cycle) is published with a
   // one-cycle valid and the counters restart with no dead cycle, so a rise
   // on the next cycle already belongs to the following window. Dropping en
   // mid-window throws the partial count away and leaves the last published
   // result untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gate_cnt  <= '0;
         edge_cnt  <= '0;
         win_ovf   <= 1'b0;
         count_out <= '0;
         valid     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               win_ovf  <= 1'b0;
               if (en) begin
                  state <= MEASURE;
               end
            end
            MEASURE: begin
               if (!en) begin
                  state    <= IDLE;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  win_ovf  <= 1'b0;
               end else if (gate_end) begin
                  count_out <= edge_next;
                  overflow  <= ovf_next;
                  valid     <= 1'b1;
                  gate_cnt  <= '0;
                  edge_cnt  <= '0;
                  win_ovf   <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + GATE_W'(1);
                  edge_cnt <= edge_next;
                  win_ovf  <= ovf_next;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_freq_meter
//
// Self-checking bench for freq_meter with a 16-cycle gate window and a 3-bit
// counter, so saturation is easy to reach. A window-level reference model
// tracks the total number of sig_in rising transitions per window and derives
// the expected count, overflow and valid from that total. Each scenario task
// also checks the hand-computed values the scenario is built around.
// ---------------------------------------------------------------------------
module tb_freq_meter;

   localparam int GATE = 16;
   localparam int W    = 3;
   localparam int SYNC = 2;
   localparam int MAXV = (1 << W) - 1;

   logic         clk;
   logic         rst;
   logic         en;
   logic         sig_in;
   logic [W-1:0] count_out;
   logic         valid;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic         mdl_hist [0:SYNC];
   bit           mdl_active;
   int           mdl_pos;
   int           mdl_total;
   int           mdl_rise;
   logic         exp_valid;
   logic [W-1:0] exp_count;
   logic         exp_ovf;

   freq_meter #(
      .GATE_CYCLES(GATE),
      .CNT_W      (W),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sig_in   (sig_in),
      .count_out(count_out),
      .valid    (valid),
      .overflow (overflow)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Window-level reference model. A sig_in rising transition sampled at
   // one clk edge is seen by the counter SYNC edges later. Each window is
   // GATE enabled cycles after the idle-to-measure cycle; its result is the
   // total number of rises in it, clamped to MAXV, with overflow whenever
   // the total exceeded MAXV.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            for (int k = 0; k <= SYNC; k++) mdl_hist[k] = 1'b0;
            mdl_active = 0;
            mdl_pos    = 0;
            mdl_total  = 0;
            exp_valid  = 1'b0;
            exp_count  = '0;
            exp_ovf    = 1'b0;
         end else begin
            mdl_rise  = (mdl_hist[SYNC-1] && !mdl_hist[SYNC]) ? 1 : 0;
            exp_valid = 1'b0;
            if (!mdl_active) begin
               if (en) begin
                  mdl_active = 1;
                  mdl_pos    = 0;
                  mdl_total  = 0;
               end
            end else if (!en) begin
               mdl_active = 0;
            end else begin
               mdl_total = mdl_total + mdl_rise;
               mdl_pos   = mdl_pos + 1;
               if (mdl_pos == GATE) begin
                  exp_valid = 1'b1;
                  exp_count = W'((mdl_total > MAXV) ? MAXV : mdl_total);
                  exp_ovf   = (mdl_total > MAXV);
                  mdl_pos   = 0;
                  mdl_total = 0;
               end
            end
            for (int k = SYNC; k > 0; k--) mdl_hist[k] = mdl_hist[k-1];
            mdl_hist[0] = sig_in;
         end
      end
   end

   // Reset clears outputs immediately, a 5-edge window reports 5, reset then
   // clears the result before any clock edge, and en=0 yields no valid.
   task automatic test_reset();
      rst    = 1'b1;
      en     = 1'b0;
      sig_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (count_out !== '0 || valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: got count_out=%0d valid=%b overflow=%b, want 0 0 0",
                  count_out, valid, overflow);
      end
      rst = 1'b0;
      for (int i = -2; i < 20; i++) begin
         en     = (i >= 0);
         sig_in = (i >= 0) && (i < 15) && (i % 3 == 0);
         @(negedge clk);
         checks++;
         if (valid !== exp_valid || count_out !== exp_count || overflow !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL reset_model t=%0t: got valid=%b count_out=%0d overflow=%b, want valid=%b count_out=%0d overflow=%b",
                     $time, valid, count_out, overflow, exp_valid, exp_count, exp_ovf);
         end
         if (i == 16) begin
            checks++;
            if (valid !== 1'b1 || count_out !== W'(5)) begin
               errors++;
               $display("[TB] FAIL reset_prep: got valid=%b count_out=%0d, want valid=1 count_out=5",
                        valid, count_out);
            end
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if (count_out !== '0 || valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_async: got count_out=%0d valid=%b overflow=%b, want 0 0 0",
                  count_out, valid, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checks++;
         if (valid !== 1'b0 || count_out !== exp_count || overflow !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL reset_idle t=%0t: got valid=%b count_out=%0d overflow=%b, want valid=0 count_out=%0d overflow=%b",
                     $time, valid, count_out, overflow, exp_count, exp_ovf);
         end
      end
   endtask

   // Period-4 input with en held: every window reports 4, 16 cycles apart.
   task automatic test_nominal();
      int nvalid;
      int last;
      nvalid = 0;
      last   = 0;
      for (int i = -3; i < 70; i++) begin
         en     = (i >= 0);
         sig_in = (i >= 0) && (((i / 2) % 2) == 1);
         @(negedge clk);
         checks++;
         if (valid !== exp_valid || count_out !== exp_count || overflow !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL nominal_model t=%0t: got valid=%b count_out=%0d overflow=%b, want valid=%b count_out=%0d overflow=%b",
                     $time, valid, count_out, overflow, exp_valid, exp_count, exp_ovf);
         end
         if (valid === 1'b1) begin
            if (nvalid > 0) begin
               checks++;
               if (i - last != GATE) begin
                  errors++;
                  $display("[TB] FAIL nominal_spacing: got %0d cycles, want %0d", i - last, GATE);
               end
            end
            checks++;
            if (count_out !== W'(4) || overflow !== 1'b0) begin
               errors++;
               $display("[TB] FAIL nominal_count: got count_out=%0d overflow=%b, want 4 0",
                        count_out, overflow);
            end
            nvalid++;
            last = i;
         end
      end
      checks++;
      if (nvalid != 4) begin
         errors++;
         $display("[TB] FAIL nominal_pulses: got %0d valid pulses, want 4", nvalid);
      end
   endtask

   // Period-2 input saturates (7, overflow); then period 10 gives 2 and 1.
   task automatic test_saturation();
      for (int i = -3; i < 50; i++) begin
         en = (i >= 0);
         if (i < 0)        sig_in = 1'b0;
         else if (i <= 16) sig_in = ((i % 2) == 0);
         else              sig_in = (((i - 17) % 10) < 5);
         @(negedge clk);
         checks++;
         if (valid !== exp_valid || count_out !== exp_count || overflow !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL sat_model t=%0t: got valid=%b count_out=%0d overflow=%b, want valid=%b count_out=%0d overflow=%b",
                     $time, valid, count_out, overflow, exp_valid, exp_count, exp_ovf);
         end
         if (i == 16 || i == 32 || i == 48) begin
            logic [W-1:0] want_cnt;
            logic         want_ovf;
            want_cnt = (i == 16) ? W'(7) : ((i == 32) ? W'(2) : W'(1));
            want_ovf = (i == 16);
            checks++;
            if (valid !== 1'b1 || count_out !== want_cnt || overflow !== want_ovf) begin
               errors++;
               $display("[TB] FAIL sat_window%0d: got valid=%b count_out=%0d overflow=%b, want valid=1 count_out=%0d overflow=%b",
                        i / GATE, valid, count_out, overflow, want_cnt, want_ovf);
            end
         end
      end
   endtask

   // en dropped at gate cycle 8 after a result of 4: no valid, result held;
   // re-enabling starts a full fresh window.
   task automatic test_abort();
      for (int i = -3; i < 60; i++) begin
         en     = (i >= 0) && (i < 24 || i >= 40);
         sig_in = (i >= 0) && (((i / 2) % 2) == 1);
         @(negedge clk);
         checks++;
         if (valid !== exp_valid || count_out !== exp_count || overflow !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL abort_model t=%0t: got valid=%b count_out=%0d overflow=%b, want valid=%b count_out=%0d overflow=%b",
                     $time, valid, count_out, overflow, exp_valid, exp_count, exp_ovf);
         end
         if (i >= 17 && i < 56) begin
            checks++;
            if (valid !== 1'b0 || count_out !== W'(4)) begin
               errors++;
               $display("[TB] FAIL abort_hold t=%0t: got valid=%b count_out=%0d, want valid=0 count_out=4",
                        $time, valid, count_out);
            end
         end
         if (i == 16 || i == 56) begin
            checks++;
            if (valid !== 1'b1 || count_out !== W'(4) || overflow !== 1'b0) begin
               errors++;
               $display("[TB] FAIL abort_result i=%0d: got valid=%b count_out=%0d overflow=%b, want 1 4 0",
                        i, valid, count_out, overflow);
            end
         end
      end
   endtask

   // sig_in high before and through enable: every window reports 0.
   task automatic test_static();
      for (int i = -5; i < 50; i++) begin
         en     = (i >= 0);
         sig_in = 1'b1;
         @(negedge clk);
         checks++;
         if (valid !== exp_valid || count_out !== exp_count || overflow !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL static_model t=%0t: got valid=%b count_out=%0d overflow=%b, want valid=%b count_out=%0d overflow=%b",
                     $time, valid, count_out, overflow, exp_valid, exp_count, exp_ovf);
         end
         if (i == 16 || i == 32 || i == 48) begin
            checks++;
            if (valid !== 1'b1 || count_out !== '0 || overflow !== 1'b0) begin
               errors++;
               $display("[TB] FAIL static_window: got valid=%b count_out=%0d overflow=%b, want 1 0 0",
                        valid, count_out, overflow);
            end
         end
      end
   endtask

   // One pulse placed so its rise lands on the last cycle of window 2
   // (pulse_i=30) or on the first cycle of window 3 (pulse_i=31).
   task automatic test_boundary(input int pulse_i, input int want2, input int want3);
      for (int i = -3; i < 50; i++) begin
         en     = (i >= 0);
         sig_in = (i == pulse_i);
         @(negedge clk);
         checks++;
         if (valid !== exp_valid || count_out !== exp_count || overflow !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL boundary_model t=%0t: got valid=%b count_out=%0d overflow=%b, want valid=%b count_out=%0d overflow=%b",
                     $time, valid, count_out, overflow, exp_valid, exp_count, exp_ovf);
         end
         if (i == 16 || i == 32 || i == 48) begin
            logic [W-1:0] want_cnt;
            want_cnt = (i == 16) ? W'(0) : ((i == 32) ? W'(want2) : W'(want3));
            checks++;
            if (valid !== 1'b1 || count_out !== want_cnt) begin
               errors++;
               $display("[TB] FAIL boundary_p%0d_i%0d: got valid=%b count_out=%0d, want valid=1 count_out=%0d",
                        pulse_i, i, valid, count_out, want_cnt);
            end
         end
      end
   endtask

   // Random sig_in timing, en drops and occasional resets against the model.
   task automatic test_random();
      int hold;
      bit fast;
      hold = 1;
      fast = 0;
      rst  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) fast = ($urandom_range(0, 3) == 0);
         hold--;
         if (hold <= 0) begin
            sig_in = ~sig_in;
            hold   = fast ? 1 : int'($urandom_range(1, 8));
         end
         if (en) begin
            if ($urandom_range(0, 199) == 0) en = 1'b0;
         end else if ($urandom_range(0, 9) == 0) begin
            en = 1'b1;
         end
         rst = ($urandom_range(0, 499) == 0);
         @(negedge clk);
         checks++;
         if (valid !== exp_valid || count_out !== exp_count || overflow !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL random_model t=%0t: got valid=%b count_out=%0d overflow=%b, want valid=%b count_out=%0d overflow=%b",
                     $time, valid, count_out, overflow, exp_valid, exp_count, exp_ovf);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      en     = 1'b0;
      sig_in = 1'b0;
      test_reset();
      test_nominal();
      test_saturation();
      test_abort();
      test_static();
      test_boundary(30, 1, 0);
      test_boundary(31, 0, 1);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] time limit");
   end

endmodule
